// File: rtl/muldiv_seq_pkg.sv
// Shared encodings for the mult/div sequencer; the op and HI/LO source
// encodings are also used by the main control FSM.
package muldiv_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_MULT_RUN = 3'd1,
    S_DIV_RUN  = 3'd2,
    S_WRITE    = 3'd3,
    S_EXCP     = 3'd4
  } state_t;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  localparam logic HILO_SRC_MULT = 1'b0;
  localparam logic HILO_SRC_DIV  = 1'b1;

  function automatic logic hilo_src_for(input logic op);
    return (op == OP_DIV) ? HILO_SRC_DIV : HILO_SRC_MULT;
  endfunction

endpackage

// File: rtl/muldiv_seq_cnt.sv
// Loadable down-counter that times the mult/div run phase.
module muldiv_seq_cnt #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  input  logic             dec,
  output logic             is_zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     cnt <= '0;
    else if (load) cnt <= value;
    else if (dec)  cnt <= cnt - 1'b1;
  end

  assign is_zero = (cnt == '0);

endmodule

// File: rtl/muldiv_seq.sv
// Mult/div resource sequencer: runs the unit for its cycle budget, then writes HI/LO.
// Build option MULDIV_DIVZERO_EXCP_EN enables the divide-by-zero exception path.
//
// state      | meaning
// S_IDLE     | waiting for start; hi_src/lo_src hold last op
// S_MULT_RUN | mult_ctrl high, counting down
// S_DIV_RUN  | div_ctrl high, counting down
// S_WRITE    | hilo_write/done pulse
// S_EXCP     | div_zero_excp pulse (only with MULDIV_DIVZERO_EXCP_EN)
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int MULT_CYCLES = 32,
  parameter int DIV_CYCLES  = 32,
  parameter int CNT_W       = 6
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic op,
  input  logic divisor_zero,
  input  logic abort,
  output logic mult_ctrl,
  output logic div_ctrl,
  output logic hilo_write,
  output logic hi_src,
  output logic lo_src,
  output logic busy,
  output logic done,
  output logic div_zero_excp
);

  state_t state;
  logic   accept;
  logic   running;
  logic   cnt_zero;
  logic   dz_taken;

  assign accept  = (state == S_IDLE) && start && !abort;
  assign running = (state == S_MULT_RUN) || (state == S_DIV_RUN);

`ifdef MULDIV_DIVZERO_EXCP_EN
  assign dz_taken = divisor_zero;
`else
  logic unused_divisor_zero;
  assign unused_divisor_zero = divisor_zero;
  assign dz_taken = 1'b0;
`endif

  muldiv_seq_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk     (clk),
    .reset   (reset),
    .load    (accept),
    .value   ((op == OP_DIV) ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1)),
    .dec     (running && !cnt_zero),
    .is_zero (cnt_zero)
  );

  // Outputs are registered alongside the state so they track it exactly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      mult_ctrl     <= 1'b0;
      div_ctrl      <= 1'b0;
      hilo_write    <= 1'b0;
      done          <= 1'b0;
      div_zero_excp <= 1'b0;
      busy          <= 1'b0;
      hi_src        <= HILO_SRC_MULT;
      lo_src        <= HILO_SRC_MULT;
    end else begin
      hilo_write    <= 1'b0;
      done          <= 1'b0;
      div_zero_excp <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            hi_src <= hilo_src_for(op);
            lo_src <= hilo_src_for(op);
            busy   <= 1'b1;
            if (op == OP_MULT) begin
              state     <= S_MULT_RUN;
              mult_ctrl <= 1'b1;
            end else if (dz_taken) begin
              state         <= S_EXCP;
              div_zero_excp <= 1'b1;
            end else begin
              state    <= S_DIV_RUN;
              div_ctrl <= 1'b1;
            end
          end
        end
        S_MULT_RUN, S_DIV_RUN: begin
          if (abort) begin
            state     <= S_IDLE;
            mult_ctrl <= 1'b0;
            div_ctrl  <= 1'b0;
            busy      <= 1'b0;
          end else if (cnt_zero) begin
            state      <= S_WRITE;
            mult_ctrl  <= 1'b0;
            div_ctrl   <= 1'b0;
            hilo_write <= 1'b1;
            done       <= 1'b1;
          end
        end
        default: begin
          state     <= S_IDLE;
          mult_ctrl <= 1'b0;
          div_ctrl  <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq (default 32-cycle budgets).
module tb_muldiv_seq;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic op = 1'b0;
  logic divisor_zero = 1'b0;
  logic abort = 1'b0;
  logic mult_ctrl, div_ctrl, hilo_write, hi_src, lo_src, busy, done, div_zero_excp;

  int errors = 0;
  int checks = 0;
  int n_mult, n_div, n_wr, n_excp;

  always #5 clk = ~clk;

  muldiv_seq dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .op            (op),
    .divisor_zero  (divisor_zero),
    .abort         (abort),
    .mult_ctrl     (mult_ctrl),
    .div_ctrl      (div_ctrl),
    .hilo_write    (hilo_write),
    .hi_src        (hi_src),
    .lo_src        (lo_src),
    .busy          (busy),
    .done          (done),
    .div_zero_excp (div_zero_excp)
  );

  task automatic chk(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accumulate output activity over n cycles, starting with the current one.
  task automatic observe(input int n, output int c_mult, output int c_div,
                         output int c_wr, output int c_excp);
    c_mult = 0; c_div = 0; c_wr = 0; c_excp = 0;
    for (int i = 0; i < n; i++) begin
      c_mult += int'(mult_ctrl);
      c_div  += int'(div_ctrl);
      c_wr   += int'(hilo_write);
      c_excp += int'(div_zero_excp);
      tick();
    end
  endtask

  // Drives a one-cycle start; returns in cycle 1 of the operation.
  task automatic pulse_start(input logic op_v, input logic dz_v);
    start = 1'b1; op = op_v; divisor_zero = dz_v;
    tick();
    start = 1'b0; divisor_zero = 1'b0;
  endtask

  initial begin
    // reset state
    tick(); tick();
    chk("rst_busy", int'(busy), 0);
    chk("rst_mult_ctrl", int'(mult_ctrl), 0);
    chk("rst_hilo_write", int'(hilo_write), 0);
    chk("rst_hi_src", int'(hi_src), 0);
    reset = 1'b0;
    tick();

    // 1: multiply
    pulse_start(1'b0, 1'b0);
    chk("t1_busy_c1", int'(busy), 1);
    observe(32, n_mult, n_div, n_wr, n_excp);
    chk("t1_mult_cycles", n_mult, 32);
    chk("t1_early_write", n_wr, 0);
    chk("t1_write_c33", int'(hilo_write), 1);
    chk("t1_done_c33", int'(done), 1);
    chk("t1_mult_off_c33", int'(mult_ctrl), 0);
    chk("t1_hi_src", int'(hi_src), 0);
    chk("t1_lo_src", int'(lo_src), 0);
    tick();
    chk("t1_busy_c34", int'(busy), 0);
    chk("t1_done_c34", int'(done), 0);

    // 2: divide
    pulse_start(1'b1, 1'b0);
    chk("t2_hi_src", int'(hi_src), 1);
    chk("t2_lo_src", int'(lo_src), 1);
    observe(32, n_mult, n_div, n_wr, n_excp);
    chk("t2_div_cycles", n_div, 32);
    chk("t2_mult_cycles", n_mult, 0);
    chk("t2_write_c33", int'(hilo_write), 1);
    chk("t2_done_c33", int'(done), 1);
    tick();
    chk("t2_busy_c34", int'(busy), 0);

    // 3: divide by zero
    pulse_start(1'b1, 1'b1);
`ifdef MULDIV_DIVZERO_EXCP_EN
    chk("t3_excp_c1", int'(div_zero_excp), 1);
    chk("t3_busy_c1", int'(busy), 1);
    chk("t3_div_ctrl_c1", int'(div_ctrl), 0);
    chk("t3_write_c1", int'(hilo_write), 0);
    chk("t3_done_c1", int'(done), 0);
    tick();
    chk("t3_busy_c2", int'(busy), 0);
    chk("t3_excp_c2", int'(div_zero_excp), 0);
    observe(40, n_mult, n_div, n_wr, n_excp);
    chk("t3_no_div", n_div, 0);
    chk("t3_no_write", n_wr, 0);
`else
    chk("t3_excp_c1", int'(div_zero_excp), 0);
    observe(32, n_mult, n_div, n_wr, n_excp);
    chk("t3_div_cycles", n_div, 32);
    chk("t3_excp_count", n_excp, 0);
    chk("t3_write_c33", int'(hilo_write), 1);
    tick();
    chk("t3_busy_c34", int'(busy), 0);
`endif

    // 4: start while busy is ignored
    pulse_start(1'b0, 1'b0);
    n_mult = 0; n_wr = 0;
    op = 1'b1;
    for (int c = 1; c <= 32; c++) begin
      start = (c == 5 || c == 20);
      n_mult += int'(mult_ctrl);
      n_wr   += int'(hilo_write);
      tick();
    end
    start = 1'b0;
    chk("t4_mult_cycles", n_mult, 32);
    chk("t4_early_write", n_wr, 0);
    chk("t4_write_c33", int'(hilo_write), 1);
    chk("t4_hi_src_kept", int'(hi_src), 0);
    tick();
    observe(40, n_mult, n_div, n_wr, n_excp);
    chk("t4_no_extra_write", n_wr, 0);
    chk("t4_no_div", n_div, 0);

    // 5a: abort during divide
    pulse_start(1'b1, 1'b0);
    observe(9, n_mult, n_div, n_wr, n_excp);
    chk("t5_div_before_abort", n_div, 9);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t5_busy_c11", int'(busy), 0);
    chk("t5_div_ctrl_c11", int'(div_ctrl), 0);
    observe(40, n_mult, n_div, n_wr, n_excp);
    chk("t5_abort_no_write", n_wr, 0);
    chk("t5_abort_no_div", n_div, 0);

    // abort in IDLE blocks a coincident start
    start = 1'b1; op = 1'b0; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("t5_idle_abort_busy", int'(busy), 0);
    chk("t5_idle_abort_mult", int'(mult_ctrl), 0);

    // 5b: reset mid multiply
    pulse_start(1'b0, 1'b0);
    tick(); tick(); tick(); tick();
    chk("t5_mult_c5", int'(mult_ctrl), 1);
    reset = 1'b1;
    #1;
    chk("t5_rst_mult", int'(mult_ctrl), 0);
    chk("t5_rst_busy", int'(busy), 0);
    chk("t5_rst_write", int'(hilo_write), 0);
    tick();
    reset = 1'b0;
    observe(40, n_mult, n_div, n_wr, n_excp);
    chk("t5_rst_no_write", n_wr, 0);

    // 6: back-to-back MULT then DIV
    pulse_start(1'b0, 1'b0);
    observe(32, n_mult, n_div, n_wr, n_excp);
    chk("t6_done1", int'(done), 1);
    tick();
    chk("t6_idle_after_done", int'(busy), 0);
    pulse_start(1'b1, 1'b0);
    chk("t6_accepted", int'(div_ctrl), 1);
    chk("t6_hi_src", int'(hi_src), 1);
    observe(32, n_mult, n_div, n_wr, n_excp);
    chk("t6_div_cycles", n_div, 32);
    chk("t6_done2", int'(done), 1);
    chk("t6_write2", int'(hilo_write), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
